// File: rtl/bus_pkg.sv
// Shared bus-target definitions: address map constants, region decode and
// the responder state encoding used by every CPU-side bus target.
package bus_pkg;

   localparam logic [15:0] RAM_LIMIT = 16'h1FFF;
   localparam logic [15:0] EXT_BASE  = 16'h8000;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_EXT,
      REG_OPEN
   } region_type;

   typedef enum logic {
      IDLE,
      EXT_WAIT
   } state_type;

   function automatic region_type decode_region(input logic [15:0] addr);
      if (addr <= RAM_LIMIT)     return REG_RAM;
      else if (addr >= EXT_BASE) return REG_EXT;
      else                       return REG_OPEN;
   endfunction

endpackage

// File: rtl/bus_ram.sv
// Single-port work RAM: synchronous write, registered read-before-write.
module bus_ram #(
   parameter int RAM_BITS = 11
)(
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [RAM_BITS-1:0] addr_i,
   input  logic [7:0]          wdata_i,
   output logic [7:0]          rdata_o
);

   logic [7:0] mem_q [2**RAM_BITS];
   logic [7:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_bus_target.sv
// CPU-side bus responder: mirrored work RAM, open-bus latch, and a
// ready-stretching req/ack bridge to the cartridge port.
module cpu_bus_target
   import bus_pkg::*;
#(
   parameter int RAM_BITS    = 11,
   parameter int EXT_TIMEOUT = 255
)(
   input  logic        I_clock,
   input  logic        I_reset,
   input  logic [15:0] I_addr,
   input  logic [7:0]  I_wr_data,
   input  logic        I_rdwr,
   input  logic        I_phy2,
   output logic [7:0]  O_rd_data,
   output logic        O_ready,
   output logic        O_ext_req,
   output logic        O_ext_we,
   output logic [14:0] O_ext_addr,
   output logic [7:0]  O_ext_wr_data,
   input  logic [7:0]  I_ext_rd_data,
   input  logic        I_ext_ack
);

   localparam logic [15:0] TMO_LAST = 16'(EXT_TIMEOUT - 1);

   state_type   state_q, state_d;
   region_type  region;
   logic        phy2_q, start, ram_we;
   logic        ram_rd_q, ram_rd_d;
   logic [7:0]  bus_q, bus_d, ram_rdata;
   logic        ready_q, ready_d, req_q, req_d, we_q, we_d;
   logic [14:0] eaddr_q, eaddr_d;
   logic [7:0]  ewd_q, ewd_d;
   logic [15:0] cnt_q, cnt_d;

   assign start  = I_phy2 & ~phy2_q;
   assign region = decode_region(I_addr);
   assign ram_we = start && (state_q == IDLE) && (region == REG_RAM) && !I_rdwr;

   bus_ram #(.RAM_BITS(RAM_BITS)) u_ram (
      .clk_i   (I_clock),
      .we_i    (ram_we),
      .addr_i  (I_addr[RAM_BITS-1:0]),
      .wdata_i (I_wr_data),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         state_q  <= IDLE;
         phy2_q   <= 1'b0;
         ram_rd_q <= 1'b0;
         bus_q    <= '0;
         ready_q  <= 1'b1;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         eaddr_q  <= '0;
         ewd_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         phy2_q   <= I_phy2;
         ram_rd_q <= ram_rd_d;
         bus_q    <= bus_d;
         ready_q  <= ready_d;
         req_q    <= req_d;
         we_q     <= we_d;
         eaddr_q  <= eaddr_d;
         ewd_q    <= ewd_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ram_rd_d = 1'b0;
      bus_d    = bus_q;
      ready_d  = ready_q;
      req_d    = req_q;
      we_d     = we_q;
      eaddr_d  = eaddr_q;
      ewd_d    = ewd_q;
      cnt_d    = cnt_q;
      // RAM output is registered, so the latch captures it one clock later.
      if (ram_rd_q) bus_d = ram_rdata;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (!I_rdwr) bus_d = I_wr_data;
               case (region)
                  REG_RAM: ram_rd_d = I_rdwr;
                  REG_EXT: begin
                     state_d = EXT_WAIT;
                     ready_d = 1'b0;
                     req_d   = 1'b1;
                     we_d    = ~I_rdwr;
                     eaddr_d = I_addr[14:0];
                     ewd_d   = I_wr_data;
                     cnt_d   = '0;
                  end
                  default: ;
               endcase
            end
         end
         EXT_WAIT: begin
            // Ack takes priority so data arriving on the timeout clock is kept.
            if (I_ext_ack || (cnt_q == TMO_LAST)) begin
               if (I_ext_ack && !we_q) bus_d = I_ext_rd_data;
               state_d = IDLE;
               ready_d = 1'b1;
               req_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bypass the RAM output so read data is visible one clock after the rise.
   assign O_rd_data     = ram_rd_q ? ram_rdata : bus_q;
   assign O_ready       = ready_q;
   assign O_ext_req     = req_q;
   assign O_ext_we      = we_q;
   assign O_ext_addr    = eaddr_q;
   assign O_ext_wr_data = ewd_q;

endmodule

// File: tb/tb_cpu_bus_target.sv
// Directed bench for cpu_bus_target: table of bus cycles plus reset/stray-ack sequences.
module tb_cpu_bus_target;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        rdwr;
   logic        phy2;
   logic [7:0]  rd_data;
   logic        ready;
   logic        ext_req;
   logic        ext_we;
   logic [14:0] ext_addr;
   logic [7:0]  ext_wd;
   logic [7:0]  ext_rd;
   logic        ext_ack;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cpu_bus_target #(.RAM_BITS(11), .EXT_TIMEOUT(TMO)) dut (
      .I_clock       (clk),
      .I_reset       (rst_n),
      .I_addr        (addr),
      .I_wr_data     (wdata),
      .I_rdwr        (rdwr),
      .I_phy2        (phy2),
      .O_rd_data     (rd_data),
      .O_ready       (ready),
      .O_ext_req     (ext_req),
      .O_ext_we      (ext_we),
      .O_ext_addr    (ext_addr),
      .O_ext_wr_data (ext_wd),
      .I_ext_rd_data (ext_rd),
      .I_ext_ack     (ext_ack)
   );

   typedef struct {
      logic [15:0] addr;
      logic        rdwr;
      logic [7:0]  wd;
      int          ack_dly;   // clocks after req is seen before ack is driven; -1 = never
      logic [7:0]  ack_data;
      logic [7:0]  exp_rd;
      int          exp_low;
      logic        exp_req;
      logic        exp_we;
      logic [14:0] exp_ea;
      logic [7:0]  exp_ewd;
   } vec_t;

   vec_t tbl[18];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // One core cycle: phy2 rises, held high while ready is low, then falls.
   task automatic bus_cycle(input vec_t v, input int idx);
      int          low_cnt;
      logic        saw_req, done;
      logic        s_we;
      logic [14:0] s_ea;
      logic [7:0]  s_wd;
      low_cnt = 0; saw_req = 1'b0; done = 1'b0;
      s_we = 1'b0; s_ea = '0; s_wd = '0;
      @(negedge clk);
      addr = v.addr; rdwr = v.rdwr; wdata = v.wd; phy2 = 1'b1;
      ext_rd = v.ack_data;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (!ready) low_cnt++;
         if (ext_req && !saw_req) begin
            saw_req = 1'b1; s_we = ext_we; s_ea = ext_addr; s_wd = ext_wd;
         end
         ext_ack = (v.ack_dly >= 0) && (k == v.ack_dly);
         if (k >= 5 && ready && !ext_ack) begin
            done = 1'b1;
            break;
         end
      end
      ext_ack = 1'b0;
      if (!done) check($sformatf("v%0d_ready_bound", idx), 32'(ready), 32'd1);
      @(negedge clk); phy2 = 1'b0;
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_rd", idx), 32'(rd_data), 32'(v.exp_rd));
      check($sformatf("v%0d_low", idx), 32'(low_cnt), 32'(v.exp_low));
      check($sformatf("v%0d_req", idx), 32'(saw_req), 32'(v.exp_req));
      if (v.exp_req) begin
         check($sformatf("v%0d_we", idx), 32'(s_we), 32'(v.exp_we));
         check($sformatf("v%0d_eaddr", idx), 32'(s_ea), 32'(v.exp_ea));
         check($sformatf("v%0d_ewd", idx), 32'(s_wd), 32'(v.exp_ewd));
      end
      check($sformatf("v%0d_req_idle", idx), 32'(ext_req), 32'd0);
   endtask

   initial begin
      vec_t tail;
      //           addr    rw    wd     ack ackd   rd    low req   we    ea        ewd
      tbl[0]  = '{16'h0123, 1'b0, 8'h5A, -1, 8'h00, 8'h5A, 0, 1'b0, 1'b0, 15'h0000, 8'h00};
      tbl[1]  = '{16'h4018, 1'b0, 8'h77, -1, 8'h00, 8'h77, 0, 1'b0, 1'b0, 15'h0000, 8'h00};
      tbl[2]  = '{16'h5000, 1'b1, 8'h00, -1, 8'h00, 8'h77, 0, 1'b0, 1'b0, 15'h0000, 8'h00};
      tbl[3]  = '{16'h0923, 1'b1, 8'h00, -1, 8'h00, 8'h5A, 0, 1'b0, 1'b0, 15'h0000, 8'h00};
      tbl[4]  = '{16'h1923, 1'b1, 8'h00, -1, 8'h00, 8'h5A, 0, 1'b0, 1'b0, 15'h0000, 8'h00};
      tbl[5]  = '{16'hC000, 1'b1, 8'h00,  4, 8'hA9, 8'hA9, 5, 1'b1, 1'b0, 15'h4000, 8'h00};
      tbl[6]  = '{16'h8001, 1'b0, 8'h3C,  2, 8'hEE, 8'h3C, 3, 1'b1, 1'b1, 15'h0001, 8'h3C};
      tbl[7]  = '{16'h5000, 1'b1, 8'h00, -1, 8'h00, 8'h3C, 0, 1'b0, 1'b0, 15'h0000, 8'h00};
      tbl[8]  = '{16'h0000, 1'b0, 8'h11, -1, 8'h00, 8'h11, 0, 1'b0, 1'b0, 15'h0000, 8'h00};
      // timeout: ready low 8 clocks, back high on the 9th edge from the rise
      tbl[9]  = '{16'hFFFC, 1'b1, 8'h00, -1, 8'h99, 8'h11, 8, 1'b1, 1'b0, 15'h7FFC, 8'h00};
      // ack on the very clock the timeout fires: data must be taken
      tbl[10] = '{16'h9000, 1'b1, 8'h00,  7, 8'h5E, 8'h5E, 8, 1'b1, 1'b0, 15'h1000, 8'h00};
      tbl[11] = '{16'h07FF, 1'b0, 8'h22, -1, 8'h00, 8'h22, 0, 1'b0, 1'b0, 15'h0000, 8'h00};
      tbl[12] = '{16'h0000, 1'b1, 8'h00, -1, 8'h00, 8'h11, 0, 1'b0, 1'b0, 15'h0000, 8'h00};
      tbl[13] = '{16'h1FFF, 1'b1, 8'h00, -1, 8'h00, 8'h22, 0, 1'b0, 1'b0, 15'h0000, 8'h00};
      tbl[14] = '{16'h0800, 1'b0, 8'h33, -1, 8'h00, 8'h33, 0, 1'b0, 1'b0, 15'h0000, 8'h00};
      tbl[15] = '{16'h07FF, 1'b1, 8'h00, -1, 8'h00, 8'h22, 0, 1'b0, 1'b0, 15'h0000, 8'h00};
      tbl[16] = '{16'h2000, 1'b1, 8'h00, -1, 8'h00, 8'h22, 0, 1'b0, 1'b0, 15'h0000, 8'h00};
      tbl[17] = '{16'h0000, 1'b1, 8'h00, -1, 8'h00, 8'h33, 0, 1'b0, 1'b0, 15'h0000, 8'h00};

      rst_n = 1'b0; addr = '0; wdata = '0; rdwr = 1'b1; phy2 = 1'b0;
      ext_rd = '0; ext_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_rd", 32'(rd_data), 32'd0);
      check("rst_req", 32'(ext_req), 32'd0);
      check("rst_we", 32'(ext_we), 32'd0);
      check("rst_eaddr", 32'(ext_addr), 32'd0);
      check("rst_ewd", 32'(ext_wd), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 18; i++) bus_cycle(tbl[i], i);

      // Reset while an external read is outstanding
      @(negedge clk);
      addr = 16'h8000; rdwr = 1'b1; phy2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_pre_req", 32'(ext_req), 32'd1);
      check("midrst_pre_ready", 32'(ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_req", 32'(ext_req), 32'd0);
      check("midrst_ready", 32'(ready), 32'd1);
      check("midrst_rd", 32'(rd_data), 32'd0);
      @(negedge clk); phy2 = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Stray ack while idle
      ext_rd = 8'hC3; ext_ack = 1'b1;
      @(negedge clk); ext_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("stray_req", 32'(ext_req), 32'd0);
      check("stray_ready", 32'(ready), 32'd1);
      check("stray_rd", 32'(rd_data), 32'd0);

      // RAM survives reset and the target still responds normally
      tail = tbl[17];
      bus_cycle(tail, 18);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
